// File: rtl/bank_write_buffer.sv
// Coalescing byte-masked write buffer in front of the 2R/1W memory bank.
// Define WRITE_BUFFER_COALESCE_EN to merge same-address requests into a pending entry.
module bank_write_buffer #(
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = $clog2(SIZE),
  parameter int COL_WIDTH  = 8,
  parameter int NB_COL     = 4,
  parameter int DEPTH      = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_WIDTH-1:0]         in_address,
  input  logic [NB_COL-1:0]             in_byte_enable,
  input  logic [NB_COL*COL_WIDTH-1:0]   in_data,
  input  logic                          drain_stall,
  output logic [NB_COL-1:0]             bank_write_enable,
  output logic [ADDR_WIDTH-1:0]         bank_write_address,
  output logic [NB_COL*COL_WIDTH-1:0]   bank_write_data,
  input  logic [ADDR_WIDTH-1:0]         read1_address,
  input  logic [ADDR_WIDTH-1:0]         read2_address,
  output logic [NB_COL-1:0]             fwd1_mask,
  output logic [NB_COL*COL_WIDTH-1:0]   fwd1_data,
  output logic [NB_COL-1:0]             fwd2_mask,
  output logic [NB_COL*COL_WIDTH-1:0]   fwd2_data,
  output logic                          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = NB_COL * COL_WIDTH;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [NB_COL-1:0]     mask_q [DEPTH];
  logic [NB_COL-1:0]     mask_d [DEPTH];
  logic [DW-1:0]         data_q [DEPTH];
  logic [DW-1:0]         data_d [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic          drain;
  logic          accept;
  logic          merge_hit;
  logic [PW-1:0] merge_idx;
  logic [PW-1:0] idx;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != CW'(DEPTH));
  assign drain    = !empty && !drain_stall;
  assign accept   = in_valid && in_ready && (|in_byte_enable);

  assign bank_write_enable  = drain ? mask_q[head_q] : '0;
  assign bank_write_address = addr_q[head_q];
  assign bank_write_data    = data_q[head_q];

`ifdef WRITE_BUFFER_COALESCE_EN
  // A head entry leaving this cycle cannot absorb the request.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == in_address &&
          !(drain && PW'(i) == head_q)) begin
        merge_hit = 1'b1;
        merge_idx = PW'(i);
      end
    end
  end
`else
  assign merge_hit = 1'b0;
  assign merge_idx = '0;
`endif

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (accept) begin
      if (merge_hit) begin
        mask_d[merge_idx] = mask_q[merge_idx] | in_byte_enable;
        for (int l = 0; l < NB_COL; l++) begin
          if (in_byte_enable[l]) begin
            data_d[merge_idx][l*COL_WIDTH +: COL_WIDTH] =
              in_data[l*COL_WIDTH +: COL_WIDTH];
          end
        end
      end else begin
        valid_d[tail_q] = 1'b1;
        addr_d[tail_q]  = in_address;
        mask_d[tail_q]  = in_byte_enable;
        data_d[tail_q]  = in_data;
        tail_d          = tail_q + 1'b1;
      end
    end
    count_d = count_q + CW'(accept && !merge_hit) - CW'(drain);
  end

  // Walk oldest to youngest so the youngest matching byte wins.
  always_comb begin
    fwd1_mask = '0;
    fwd1_data = '0;
    fwd2_mask = '0;
    fwd2_data = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      for (int l = 0; l < NB_COL; l++) begin
        if (valid_q[idx] && mask_q[idx][l]) begin
          if (addr_q[idx] == read1_address) begin
            fwd1_mask[l] = 1'b1;
            fwd1_data[l*COL_WIDTH +: COL_WIDTH] =
              data_q[idx][l*COL_WIDTH +: COL_WIDTH];
          end
          if (addr_q[idx] == read2_address) begin
            fwd2_mask[l] = 1'b1;
            fwd2_data[l*COL_WIDTH +: COL_WIDTH] =
              data_q[idx][l*COL_WIDTH +: COL_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        mask_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_bank_write_buffer.sv
// Bench for bank_write_buffer: directed vector table, reset sequence,
// then random traffic against a queue-based reference model.
module tb_bank_write_buffer;

  localparam int SIZE  = 1024;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_address = '0;
  logic [3:0]    in_byte_enable = '0;
  logic [DW-1:0] in_data = '0;
  logic          drain_stall = 1'b1;
  logic [3:0]    bank_write_enable;
  logic [AW-1:0] bank_write_address;
  logic [DW-1:0] bank_write_data;
  logic [AW-1:0] read1_address = '0;
  logic [AW-1:0] read2_address = '0;
  logic [3:0]    fwd1_mask;
  logic [DW-1:0] fwd1_data;
  logic [3:0]    fwd2_mask;
  logic [DW-1:0] fwd2_data;
  logic          empty;

  always #5 clock = ~clock;

  bank_write_buffer #(
    .SIZE(SIZE), .ADDR_WIDTH(AW), .COL_WIDTH(8),
    .NB_COL(4), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_address(in_address), .in_byte_enable(in_byte_enable),
    .in_data(in_data), .drain_stall(drain_stall),
    .bank_write_enable(bank_write_enable),
    .bank_write_address(bank_write_address),
    .bank_write_data(bank_write_data),
    .read1_address(read1_address), .read2_address(read2_address),
    .fwd1_mask(fwd1_mask), .fwd1_data(fwd1_data),
    .fwd2_mask(fwd2_mask), .fwd2_data(fwd2_data),
    .empty(empty)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[l*8 +: 8] = {8{m[l]}};
    return r;
  endfunction

  typedef struct {
    logic v; logic [AW-1:0] a; logic [3:0] be; logic [31:0] d;
    logic st; logic [AW-1:0] r;
    logic rdy; logic emp; logic [3:0] bwe; logic [AW-1:0] ba;
    logic [31:0] bd; logic [3:0] fm; logic [31:0] fd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [AW-1:0] a,
                     input logic [3:0] be, input logic [31:0] d,
                     input logic st, input logic [AW-1:0] r,
                     input logic rdy, input logic emp,
                     input logic [3:0] bwe, input logic [AW-1:0] ba,
                     input logic [31:0] bd, input logic [3:0] fm,
                     input logic [31:0] fd);
    vec_t x;
    x.v = v; x.a = a; x.be = be; x.d = d; x.st = st; x.r = r;
    x.rdy = rdy; x.emp = emp; x.bwe = bwe; x.ba = ba; x.bd = bd;
    x.fm = fm; x.fd = fd;
    tbl.push_back(x);
  endtask

  typedef struct {
    logic [AW-1:0] a; logic [3:0] m; logic [31:0] d;
  } ent_t;

  ent_t mq[$];

  function automatic void mfwd(input logic [AW-1:0] ra,
                               output logic [3:0] m,
                               output logic [31:0] d);
    m = '0;
    d = '0;
    for (int l = 0; l < 4; l++) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].a == ra && mq[i].m[l]) begin
          m[l] = 1'b1;
          d[l*8 +: 8] = mq[i].d[l*8 +: 8];
          break;
        end
      end
    end
  endfunction

  function automatic void mstep(input logic v, input logic [AW-1:0] a,
                                input logic [3:0] be,
                                input logic [31:0] d, input logic st);
    bit dr;
    bit acc;
    bit merged;
    ent_t e;
    dr = (mq.size() != 0) && !st;
    acc = v && (mq.size() < DEPTH) && (be != 0);
    merged = 0;
    if (acc) begin
`ifdef WRITE_BUFFER_COALESCE_EN
      for (int i = (dr ? 1 : 0); i < mq.size(); i++) begin
        if (!merged && mq[i].a == a) begin
          for (int l = 0; l < 4; l++)
            if (be[l]) mq[i].d[l*8 +: 8] = d[l*8 +: 8];
          mq[i].m = mq[i].m | be;
          merged = 1;
        end
      end
`endif
      if (!merged) begin
        e.a = a; e.m = be; e.d = d;
        mq.push_back(e);
      end
    end
    if (dr) void'(mq.pop_front());
  endfunction

  initial begin
    logic [3:0]  em1, em2, ebwe;
    logic [31:0] ed1, ed2, bm;
    vec_t x;

    // one write, drained next cycle
    add(1, 10'h010, 4'hF, 32'hDEADBEEF, 0, 10'h010, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h010, 1, 0, 4'hF, 10'h010, 32'hDEADBEEF,
        4'hF, 32'hDEADBEEF);
    add(0, 0, 0, 0, 0, 10'h010, 1, 1, 0, 0, 0, 0, 0);
    // fill, reject while full, drain in order
    add(1, 10'h001, 4'hF, 32'h11111111, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 10'h002, 4'hF, 32'h22222222, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 10'h003, 4'hF, 32'h33333333, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 10'h004, 4'hF, 32'h44444444, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 10'h005, 4'hF, 32'h55555555, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 10'h001, 32'h11111111, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 10'h002, 32'h22222222, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 10'h003, 32'h33333333, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 10'h004, 32'h44444444, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    // forwarding of two partial writes to one row
    add(1, 10'h020, 4'h3, 32'h0000AAAA, 1, 10'h020, 1, 1, 0, 0, 0, 0, 0);
    add(1, 10'h020, 4'h6, 32'h00BBBB00, 1, 10'h020, 1, 0, 0, 0, 0,
        4'h3, 32'h0000AAAA);
    add(0, 0, 0, 0, 1, 10'h020, 1, 0, 0, 0, 0, 4'h7, 32'h00BBBBAA);
`ifdef WRITE_BUFFER_COALESCE_EN
    add(0, 0, 0, 0, 0, 10'h020, 1, 0, 4'h7, 10'h020, 32'h00BBBBAA,
        4'h7, 32'h00BBBBAA);
    add(0, 0, 0, 0, 0, 10'h020, 1, 1, 0, 0, 0, 0, 0);
`else
    add(0, 0, 0, 0, 0, 10'h020, 1, 0, 4'h3, 10'h020, 32'h0000AAAA,
        4'h7, 32'h00BBBBAA);
    add(0, 0, 0, 0, 0, 10'h020, 1, 0, 4'h6, 10'h020, 32'h00BBBB00,
        4'h6, 32'h00BBBB00);
`endif
    add(0, 0, 0, 0, 0, 10'h020, 1, 1, 0, 0, 0, 0, 0);
    // same-row request while the head drains allocates a fresh entry
    add(1, 10'h030, 4'hF, 32'h12345678, 1, 10'h030, 1, 1, 0, 0, 0, 0, 0);
    add(1, 10'h030, 4'hF, 32'h9ABCDEF0, 0, 10'h030, 1, 0, 4'hF, 10'h030,
        32'h12345678, 4'hF, 32'h12345678);
    add(0, 0, 0, 0, 0, 10'h030, 1, 0, 4'hF, 10'h030, 32'h9ABCDEF0,
        4'hF, 32'h9ABCDEF0);
    add(0, 0, 0, 0, 0, 10'h030, 1, 1, 0, 0, 0, 0, 0);
    // zero-mask request is dropped
    add(1, 10'h040, 4'h0, 32'hFFFFFFFF, 0, 10'h040, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10'h040, 1, 1, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clock);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_bwe", bank_write_enable, 0);
    chk("rst_fwd1", fwd1_mask, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      x = tbl[i];
      in_valid = x.v; in_address = x.a; in_byte_enable = x.be;
      in_data = x.d; drain_stall = x.st;
      read1_address = x.r; read2_address = x.r;
      #1;
      bm = lane_mask(x.bwe);
      chk($sformatf("v%0d_ready", i), in_ready, x.rdy);
      chk($sformatf("v%0d_empty", i), empty, x.emp);
      chk($sformatf("v%0d_bwe", i), bank_write_enable, x.bwe);
      if (x.bwe != 0) begin
        chk($sformatf("v%0d_baddr", i), bank_write_address, x.ba);
        chk($sformatf("v%0d_bdata", i), bank_write_data & bm, x.bd & bm);
      end
      chk($sformatf("v%0d_f1m", i), fwd1_mask, x.fm);
      chk($sformatf("v%0d_f1d", i), fwd1_data, x.fd);
      chk($sformatf("v%0d_f2m", i), fwd2_mask, x.fm);
      chk($sformatf("v%0d_f2d", i), fwd2_data, x.fd);
    end

    // async reset with three pending entries
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      in_valid = 1; in_address = AW'(10'h050 + i);
      in_byte_enable = 4'hF; in_data = 32'hC0DE0000 + i;
      drain_stall = 1;
    end
    @(negedge clock);
    in_valid = 0; drain_stall = 0;
    read1_address = 10'h050; read2_address = 10'h051;
    #1;
    chk("pre_rst_bwe", bank_write_enable, 4'hF);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_ready", in_ready, 1);
    chk("arst_bwe", bank_write_enable, 0);
    chk("arst_f1m", fwd1_mask, 0);
    chk("arst_f2m", fwd2_mask, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      chk("post_rst_bwe", bank_write_enable, 0);
      chk("post_rst_empty", empty, 1);
    end
    mq.delete();

    // random traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      in_valid = ($urandom_range(99) < 60);
      in_address = AW'($urandom_range(7));
      in_byte_enable = ($urandom_range(9) == 0) ? 4'h0
                                                 : 4'($urandom_range(15));
      in_data = $urandom;
      drain_stall = ($urandom_range(99) < 40);
      read1_address = AW'($urandom_range(7));
      read2_address = AW'($urandom_range(7));
      ebwe = (mq.size() != 0 && !drain_stall) ? mq[0].m : 4'h0;
      mfwd(read1_address, em1, ed1);
      mfwd(read2_address, em2, ed2);
      #1;
      chk("r_ready", in_ready, (mq.size() < DEPTH));
      chk("r_empty", empty, (mq.size() == 0));
      chk("r_bwe", bank_write_enable, ebwe);
      if (ebwe != 0) begin
        bm = lane_mask(ebwe);
        chk("r_baddr", bank_write_address, mq[0].a);
        chk("r_bdata", bank_write_data & bm, mq[0].d & bm);
      end
      chk("r_f1m", fwd1_mask, em1);
      chk("r_f1d", fwd1_data, ed1);
      chk("r_f2m", fwd2_mask, em2);
      chk("r_f2d", fwd2_data, ed2);
      mstep(in_valid, in_address, in_byte_enable, in_data, drain_stall);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
